// File: rtl/gmt_pkg.sv
// Shared GMT definitions: frame geometry, transmitter states and the parity helper
// used by both the transmit and receive paths.
package gmt_pkg;

    localparam int unsigned c_GMT_FRAME_BITS = 34;
    localparam int unsigned c_GMT_DATA_BITS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_GAP
    } t_gmt_tx_state;

    // Odd parity: returned bit makes (ones in data + parity) odd.
    function automatic logic f_gmt_odd_parity(input logic [c_GMT_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/gmt_tx_fifo.sv
// Single-clock message FIFO with registered fill count and full/empty flags.
module gmt_tx_fifo #(
    parameter int unsigned g_depth = 4,
    parameter int unsigned g_width = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [g_width-1:0]         data_i,
    input  logic                       pop_i,
    output logic [g_width-1:0]         head_o,
    output logic [$clog2(g_depth):0]   count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned LP_AW = $clog2(g_depth);
    localparam int unsigned LP_CW = LP_AW + 1;
    localparam logic [LP_CW-1:0] LP_FULL = LP_CW'(g_depth);
    localparam logic [LP_CW-1:0] LP_ONE  = LP_CW'(1);

    logic [g_width-1:0] r_mem [g_depth];
    logic [LP_AW-1:0]   r_wr;
    logic [LP_AW-1:0]   r_rd;
    logic [LP_CW-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               w_push;
    logic               w_pop;
    logic [LP_CW-1:0]   w_count_nxt;

    assign w_push = push_i && !r_full;
    assign w_pop  = pop_i && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + LP_ONE;
            2'b01:   w_count_nxt = r_count - LP_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == LP_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign head_o  = r_mem[r_rd];
    assign count_o = r_count;
    assign full_o  = r_full;
    assign empty_o = r_empty;

endmodule

// File: rtl/gmt_tx_encoder.sv
// GMT transmitter: buffers 32-bit messages and sends each as a Manchester-coded
// frame (start bit, data MSB first, odd parity) followed by an idle gap.
module gmt_tx_encoder import gmt_pkg::*; #(
    parameter int unsigned g_half_bit_cycles = 40,
    parameter int unsigned g_fifo_depth      = 4,
    parameter int unsigned g_gap_bits        = 4
) (
    input  logic                            clk_sys_i,
    input  logic                            rst_sys_i,
    input  logic                            en_i,
    input  logic [31:0]                     data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic                            gmt_o,
    output logic                            busy_o,
    output logic                            done_p_o,
    output logic [$clog2(g_fifo_depth):0]   count_o
);

    localparam int unsigned LP_HW      = $clog2(g_half_bit_cycles);
    localparam int unsigned LP_GAP_CYC = g_gap_bits * 2 * g_half_bit_cycles;
    localparam int unsigned LP_GW      = (LP_GAP_CYC > 2) ? $clog2(LP_GAP_CYC) : 1;
    localparam logic [LP_HW-1:0] LP_HALF_LOAD = LP_HW'(g_half_bit_cycles - 1);
    localparam logic [LP_HW-1:0] LP_HALF_ONE  = LP_HW'(1);
    // The IDLE cycle preceding LOAD is the final gap cycle, so GAP itself lasts one less.
    localparam logic [LP_GW-1:0] LP_GAP_LOAD  = LP_GW'((LP_GAP_CYC >= 2) ? LP_GAP_CYC - 2 : 0);
    localparam logic [LP_GW-1:0] LP_GAP_ONE   = LP_GW'(1);

    t_gmt_tx_state       r_state;
    logic [LP_HW-1:0]    r_cnt;
    logic [LP_GW-1:0]    r_gap_cnt;
    logic                r_half;
    logic [4:0]          r_idx;
    logic [31:0]         r_shift;
    logic                r_parity;
    logic                r_gmt;
    logic                r_busy;
    logic                r_done;

    logic [31:0]         w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign ready_o = !w_full && !rst_sys_i;
    assign w_push  = valid_i && ready_o;
    assign w_pop   = (r_state == ST_LOAD);

    gmt_tx_fifo #(
        .g_depth (g_fifo_depth),
        .g_width (32)
    ) u_fifo (
        .clk_i   (clk_sys_i),
        .rst_i   (rst_sys_i),
        .push_i  (w_push),
        .data_i  (data_i),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .count_o (count_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_half    <= 1'b0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_gmt     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en_i && !w_empty) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_shift  <= w_head;
                    r_parity <= f_gmt_odd_parity(w_head);
                    r_state  <= ST_START;
                    r_gmt    <= 1'b1;
                    r_half   <= 1'b0;
                    r_cnt    <= LP_HALF_LOAD;
                end
                ST_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - LP_HALF_ONE;
                    end else if (!r_half) begin
                        r_half <= 1'b1;
                        r_gmt  <= 1'b0;
                        r_cnt  <= LP_HALF_LOAD;
                    end else begin
                        r_half  <= 1'b0;
                        r_cnt   <= LP_HALF_LOAD;
                        r_gmt   <= r_shift[31];
                        r_idx   <= 5'd31;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - LP_HALF_ONE;
                    end else if (!r_half) begin
                        r_half <= 1'b1;
                        r_gmt  <= ~r_shift[31];
                        r_cnt  <= LP_HALF_LOAD;
                    end else begin
                        r_half <= 1'b0;
                        r_cnt  <= LP_HALF_LOAD;
                        if (r_idx == 5'd0) begin
                            r_gmt   <= r_parity;
                            r_state <= ST_PARITY;
                        end else begin
                            r_idx   <= r_idx - 5'd1;
                            r_shift <= {r_shift[30:0], 1'b0};
                            r_gmt   <= r_shift[30];
                        end
                    end
                end
                ST_PARITY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - LP_HALF_ONE;
                        if (r_half && r_cnt == LP_HALF_ONE) r_done <= 1'b1;
                    end else if (!r_half) begin
                        r_half <= 1'b1;
                        r_gmt  <= ~r_parity;
                        r_cnt  <= LP_HALF_LOAD;
                    end else begin
                        r_half <= 1'b0;
                        r_gmt  <= 1'b0;
                        if (g_gap_bits == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap_cnt <= LP_GAP_LOAD;
                            r_state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - LP_GAP_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_gmt   <= 1'b0;
                end
            endcase
        end
    end

    assign gmt_o    = r_gmt;
    assign busy_o   = r_busy;
    assign done_p_o = r_done;

endmodule

// File: tb/tb_gmt_tx_encoder.sv
// Directed bench for gmt_tx_encoder: cycle-exact Manchester frame checks, FIFO fill,
// enable gating, mid-frame reset, and a gap-less configuration.
module tb_gmt_tx_encoder;

    logic        clk;
    logic        rst;
    logic        en, valid;
    logic [31:0] data;
    logic        ready, gmt, busy, done;
    logic [2:0]  count;

    logic        en0, valid0;
    logic [31:0] data0;
    logic        ready0, gmt0, busy0, done0;
    logic [1:0]  count0;

    logic        sel;
    logic        w_gmt, w_busy, w_done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    gmt_tx_encoder #(
        .g_half_bit_cycles (40),
        .g_fifo_depth      (4),
        .g_gap_bits        (4)
    ) u_dut (
        .clk_sys_i (clk),
        .rst_sys_i (rst),
        .en_i      (en),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready),
        .gmt_o     (gmt),
        .busy_o    (busy),
        .done_p_o  (done),
        .count_o   (count)
    );

    gmt_tx_encoder #(
        .g_half_bit_cycles (2),
        .g_fifo_depth      (2),
        .g_gap_bits        (0)
    ) u_dut_g0 (
        .clk_sys_i (clk),
        .rst_sys_i (rst),
        .en_i      (en0),
        .data_i    (data0),
        .valid_i   (valid0),
        .ready_o   (ready0),
        .gmt_o     (gmt0),
        .busy_o    (busy0),
        .done_p_o  (done0),
        .count_o   (count0)
    );

    assign w_gmt  = sel ? gmt0  : gmt;
    assign w_busy = sel ? busy0 : busy;
    assign w_done = sel ? done0 : done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input string tag, input int unsigned bound, output int unsigned c);
        c = 0;
        while (w_gmt !== 1'b1 && c < bound) begin
            step();
            c++;
        end
        if (w_gmt !== 1'b1) chk({tag, " rise timeout"}, 64'(w_gmt), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned c;
        c = 0;
        while (w_busy !== 1'b0 && c < 1000) begin
            step();
            c++;
        end
        if (w_busy !== 1'b0) chk({tag, " idle timeout"}, 64'(w_busy), 64'd0);
    endtask

    // Called on the first cycle of a frame; checks every cycle of it.
    task automatic expect_frame(input string tag, input logic [31:0] d, input logic par);
        logic [33:0] fr;
        int unsigned h, n, bad, done_n, done_k, b, hf;
        logic e;
        fr = {1'b1, d, par};
        h = sel ? 2 : 40;
        n = 68 * h;
        bad = 0; done_n = 0; done_k = 0;
        for (int unsigned k = 0; k < n; k++) begin
            b  = k / (2 * h);
            hf = (k / h) % 2;
            e  = fr[33 - b] ^ hf[0];
            if (w_gmt !== e || w_busy !== 1'b1) bad++;
            if (w_done === 1'b1) begin
                done_n++;
                done_k = k;
            end
            step();
        end
        chk({tag, " bit errors"}, 64'(bad), 64'd0);
        chk({tag, " done position"}, 64'(done_k), 64'(n - 1));
        chk({tag, " done pulses"}, 64'(done_n), 64'd1);
        chk({tag, " low after frame"}, 64'(w_gmt), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, " ready in reset"}, 64'(ready), 64'd0);
        step();
        rst = 1'b0;
        chk({tag, " gmt"}, 64'(gmt), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " count"}, 64'(count), 64'd0);
        #1;
        chk({tag, " ready out of reset"}, 64'(ready), 64'd1);
    endtask

    logic [31:0] w3 [6] = '{32'hDEADBEEF, 32'h00000001, 32'h12345678,
                            32'hA5A5A5A5, 32'h80000003, 32'h55555555};
    logic        p3 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int unsigned c, bad;
        rst = 1'b1; en = 1'b1; valid = 1'b0; data = '0;
        en0 = 1'b1; valid0 = 1'b0; data0 = '0; sel = 1'b0;
        step();
        do_reset("reset");

        // single word: start bit two cycles after the push
        data = 32'hDEADBEEF; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("t1 count after push", 64'(count), 64'd1);
        wait_rise("t1", 10, c);
        chk("t1 rise latency", 64'(c), 64'd2);
        expect_frame("t1", 32'hDEADBEEF, 1'b1);
        chk("t1 busy in gap", 64'(busy), 64'd1);
        wait_idle("t1");

        // back-to-back frames and exact inter-frame spacing
        data = 32'h00000000; valid = 1'b1;
        step();
        data = 32'hFFFFFFFF;
        step();
        valid = 1'b0;
        wait_rise("t2a", 10, c);
        expect_frame("t2a", 32'h00000000, 1'b1);
        c = 0;
        while (gmt !== 1'b1 && c < 1000) begin
            step();
            c++;
        end
        chk("t2 gap cycles", 64'(c), 64'd321);
        expect_frame("t2b", 32'hFFFFFFFF, 1'b1);
        wait_idle("t2");

        // overfill with valid held high; all accepted words go out in order
        fork
            begin
                int unsigned acc;
                acc = 0;
                for (int i = 0; i < 6; i++) begin
                    data = w3[i]; valid = 1'b1;
                    if (ready) acc++;
                    step();
                end
                valid = 1'b0;
                chk("t3 accepted", 64'(acc), 64'd5);
                chk("t3 ready when full", 64'(ready), 64'd0);
                chk("t3 count when full", 64'(count), 64'd4);
            end
            begin
                int unsigned cb;
                for (int i = 0; i < 5; i++) begin
                    wait_rise($sformatf("t3 f%0d", i), 400, cb);
                    expect_frame($sformatf("t3 f%0d", i), w3[i], p3[i]);
                end
            end
        join
        wait_idle("t3");

        // en_i dropped mid-frame: frame and gap finish, then hold idle
        do_reset("t4 reset");
        for (int i = 0; i < 3; i++) begin
            data = w3[i + 1]; valid = 1'b1;
            step();
        end
        valid = 1'b0;
        wait_rise("t4a", 10, c);
        en = 1'b0;
        expect_frame("t4a", 32'h00000001, 1'b0);
        wait_idle("t4");
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            if (gmt !== 1'b0 || busy !== 1'b0 || count !== 3'd2) bad++;
            step();
        end
        chk("t4 held while disabled", 64'(bad), 64'd0);
        en = 1'b1;
        wait_rise("t4b", 10, c);
        chk("t4 restart latency", 64'(c), 64'd2);
        expect_frame("t4b", 32'h12345678, 1'b0);

        // reset in the middle of the third word's data bits
        wait_rise("t5", 400, c);
        repeat (200) step();
        do_reset("t5 reset");
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if (gmt !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
            step();
        end
        chk("t5 quiet after reset", 64'(bad), 64'd0);
        data = 32'hA5A5A5A5; valid = 1'b1;
        step();
        valid = 1'b0;
        wait_rise("t5b", 10, c);
        chk("t5 rise latency", 64'(c), 64'd2);
        expect_frame("t5b", 32'hA5A5A5A5, 1'b1);

        // zero-gap configuration
        sel = 1'b1;
        data0 = 32'h12345678; valid0 = 1'b1;
        step();
        data0 = 32'h0000FFFF;
        step();
        valid0 = 1'b0;
        wait_rise("t6a", 10, c);
        expect_frame("t6a", 32'h12345678, 1'b0);
        wait_rise("t6b", 10, c);
        expect_frame("t6b", 32'h0000FFFF, 1'b1);
        wait_idle("t6");
        chk("t6 count drained", 64'(count0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
